// File: rtl/window_buffer.sv
// Circular input-window buffer feeding a PE's MAC: takes 4-byte rows in at the
// tail, serves one byte at an offset from the head, and slides the head by a stride.
module window_buffer #(
    parameter int DEPTH  = 16,
    parameter int IW     = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              load,
    input  logic [DATA_W-1:0] inp [0:3],
    input  logic              advance,
    input  logic [IW-1:0]     slide_amt,
    input  logic [IW-1:0]     read_index,
    output logic [DATA_W-1:0] outp,
    output logic [IW:0]       count,
    output logic              full,
    output logic              empty,
    output logic              err
);

    localparam int          ROW      = 4;
    localparam logic [IW:0] ROW_CNT  = (IW+1)'(ROW);
    localparam logic [IW:0] FULL_LIM = (IW+1)'(DEPTH - ROW);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IW-1:0]     head;
    logic [IW-1:0]     tail;
    logic [IW:0]       count_nxt;
    logic [IW-1:0]     rd_addr;
    logic              clear;
    logic              load_ok;
    logic              adv_ok;
    logic              load_drop;
    logic              adv_drop;

    function automatic logic [IW:0] next_count(
        input logic [IW:0]   cur,
        input logic          add_row,
        input logic          sub,
        input logic [IW-1:0] amt
    );
        logic [IW:0] r;
        r = cur;
        if (add_row) r = r + ROW_CNT;
        if (sub)     r = r - {1'b0, amt};
        return r;
    endfunction

    // Acceptance is judged on the registered count, so a row can never land
    // in space being freed by an advance in the same cycle.
    always_comb begin
        clear     = rst | flush;
        full      = count > FULL_LIM;
        empty     = count == '0;
        load_ok   = load & ~full;
        adv_ok    = advance & ({1'b0, slide_amt} <= count);
        load_drop = load & full;
        adv_drop  = advance & ~adv_ok;
        count_nxt = next_count(count, load_ok, adv_ok, slide_amt);
    end

    always_comb begin
        rd_addr = head + read_index;
        outp    = ({1'b0, read_index} < count) ? mem[rd_addr] : '0;
    end

    // Storage is never cleared; bytes beyond count are masked on read.
    always_ff @(posedge clk) begin
        if (!clear && load_ok) begin
            for (int k = 0; k < ROW; k++) begin
                mem[tail + IW'(k)] <= inp[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            err   <= 1'b0;
        end else begin
            if (load_ok) tail <= tail + IW'(ROW);
            if (adv_ok)  head <= head + slide_amt;
            count <= count_nxt;
            if (load_drop || adv_drop) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_window_buffer.sv
// Scoreboard bench for window_buffer: a byte-queue model predicts every cycle's
// outputs, and a negedge monitor compares them against the DUT.
module tb_window_buffer;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst, flush, load, advance;
    logic [7:0] inp [0:3];
    logic [3:0] slide_amt, read_index;
    logic [7:0] outp;
    logic [4:0] count;
    logic       full, empty, err;

    typedef struct packed {
        logic [7:0] outp;
        logic [4:0] count;
        logic       full;
        logic       empty;
        logic       err;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] win[$];
    logic       m_err;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    window_buffer #(.DEPTH(DEPTH), .IW(4), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .flush(flush), .load(load), .inp(inp),
        .advance(advance), .slide_amt(slide_amt), .read_index(read_index),
        .outp(outp), .count(count), .full(full), .empty(empty), .err(err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("outp",  32'(outp),  32'(e.outp));
            chk("count", 32'(count), 32'(e.count));
            chk("full",  32'(full),  32'(e.full));
            chk("empty", 32'(empty), 32'(e.empty));
            chk("err",   32'(err),   32'(e.err));
        end
    end

    // Drive one cycle, predict the outputs seen before the edge, then update the model.
    task automatic step(input logic r, input logic f, input logic l,
                        input logic [7:0] d0, input logic [7:0] d1,
                        input logic [7:0] d2, input logic [7:0] d3,
                        input logic a, input logic [3:0] s, input logic [3:0] ri);
        exp_t e;
        int   n;
        logic lok, aok;
        rst = r; flush = f; load = l; advance = a; slide_amt = s; read_index = ri;
        inp[0] = d0; inp[1] = d1; inp[2] = d2; inp[3] = d3;
        n       = win.size();
        e.count = 5'(n);
        e.full  = n > DEPTH - 4;
        e.empty = n == 0;
        e.err   = m_err;
        e.outp  = (int'(ri) < n) ? win[ri] : 8'h00;
        exp_q.push_back(e);
        @(posedge clk);
        if (r || f) begin
            win.delete();
            m_err = 1'b0;
        end else begin
            lok = l && (n <= DEPTH - 4);
            aok = a && (int'(s) <= n);
            if (l && !lok) m_err = 1'b1;
            if (a && !aok) m_err = 1'b1;
            if (aok) for (int i = 0; i < int'(s); i++) void'(win.pop_front());
            if (lok) begin
                win.push_back(d0); win.push_back(d1);
                win.push_back(d2); win.push_back(d3);
            end
        end
        #1;
    endtask

    task automatic idle(input logic [3:0] ri);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, ri);
    endtask

    task automatic ld(input logic [7:0] d0, input logic [7:0] d1,
                      input logic [7:0] d2, input logic [7:0] d3);
        step(0, 0, 1, d0, d1, d2, d3, 0, 0, 0);
    endtask

    task automatic do_flush();
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1; flush = 0; load = 0; advance = 0; slide_amt = 0; read_index = 0;
        for (int k = 0; k < 4; k++) inp[k] = 8'h00;
        m_err = 1'b0;
        @(posedge clk);
        win.delete();
        #1;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) idle(4'(i));

        // sequential loads
        ld(1, 2, 3, 4);
        ld(5, 6, 7, 8);
        for (int i = 0; i < 9; i++) idle(4'(i));

        // fill, overflow, flush
        do_flush();
        for (int i = 0; i < 4; i++) ld(8'(16 + 4*i), 8'(17 + 4*i), 8'(18 + 4*i), 8'(19 + 4*i));
        ld(8'hEE, 8'hEE, 8'hEE, 8'hEE);
        for (int i = 0; i < 16; i++) idle(4'(i));
        do_flush();
        idle(0);

        // slide and wrap
        for (int i = 0; i < 4; i++) ld(8'(4*i), 8'(4*i + 1), 8'(4*i + 2), 8'(4*i + 3));
        step(0, 0, 0, 0, 0, 0, 0, 1, 6, 0);
        idle(0);
        ld(8'hA0, 8'hA1, 8'hA2, 8'hA3);
        for (int i = 0; i < 14; i++) idle(4'(i));

        // simultaneous load and advance at count 12
        do_flush();
        for (int i = 0; i < 3; i++) ld(8'(40 + 4*i), 8'(41 + 4*i), 8'(42 + 4*i), 8'(43 + 4*i));
        step(0, 0, 1, 8'hB0, 8'hB1, 8'hB2, 8'hB3, 1, 3, 0);
        for (int i = 0; i < 14; i++) idle(4'(i));

        // illegal advance, then reset alongside a load
        do_flush();
        ld(9, 10, 11, 12);
        step(0, 0, 0, 0, 0, 0, 0, 1, 5, 0);
        for (int i = 0; i < 5; i++) idle(4'(i));
        step(1, 0, 1, 1, 2, 3, 4, 0, 0, 0);
        idle(0);
        idle(1);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 1) == 1,
                 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                 $urandom_range(0, 2) == 0,
                 ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6)),
                 4'($urandom_range(0, 15)));
        end
        idle(0);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
